// File: rtl/multicycle_alu_if.sv
// -----------------------------------------------------------------------------
// multicycle_alu_if
// Request/response bundle between the execute-stage control unit and the
// multicycle ALU.
//   master (control unit): drives in_valid, ALUOperation, A, B, Shamt;
//                          observes in_ready, out_valid, ALUResult, Zero, busy
//   slave  (ALU)         : the mirror image
// -----------------------------------------------------------------------------
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [3:0]         ALUOperation;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [SHAMT_W-1:0] Shamt;
    logic               out_valid;
    logic [WIDTH-1:0]   ALUResult;
    logic               Zero;
    logic               busy;

    modport master (
        output in_valid, ALUOperation, A, B, Shamt,
        input  in_ready, out_valid, ALUResult, Zero, busy
    );

    modport slave (
        input  in_valid, ALUOperation, A, B, Shamt,
        output in_ready, out_valid, ALUResult, Zero, busy
    );
endinterface

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
// Registered execute-stage ALU. Logic/arithmetic/shift/compare operations and
// HI/LO readback complete one cycle after accept; unsigned multiply and divide
// iterate for WIDTH cycles (shift-add / restoring divide) and write HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of multicycle_alu_if
//           in_valid/in_ready   request handshake
//           ALUOperation,A,B,Shamt  operands, sampled on accept
//           out_valid           one-cycle pulse when ALUResult/Zero update
//           ALUResult, Zero     registered result and zero flag
//           busy                multiply/divide iteration in progress
// -----------------------------------------------------------------------------
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    multicycle_alu_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int HALF    = WIDTH / 2;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_LUI   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   result_p1;
    logic               zero_p1;

    // Iteration working set: wk_hi is the partial product high half or the
    // partial remainder, wk_lo the multiplier or dividend/quotient.
    logic               is_div;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   wk_hi, wk_lo;

    logic               accept, is_mdu, op_div, last_step;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH:0]     sum, shifted, trial;

    function automatic logic [WIDTH-1:0] alu_op(
        input logic [3:0]         op,
        input logic [WIDTH-1:0]   a,
        input logic [WIDTH-1:0]   b,
        input logic [SHAMT_W-1:0] sh,
        input logic [WIDTH-1:0]   hi_v,
        input logic [WIDTH-1:0]   lo_v
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic        [WIDTH-1:0] r;
        a_s = a;
        b_s = b;
        r   = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_LUI:  r = {b[HALF-1:0], {HALF{1'b0}}};
            OP_SLL:  r = b << sh;
            OP_SRL:  r = b >> sh;
            OP_SRA:  r = b_s >>> sh;
            OP_SLT:  r = (a_s < b_s) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            OP_MFHI: r = hi_v;
            OP_MFLO: r = lo_v;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign op_div    = (bus.ALUOperation == OP_DIVU);
    assign is_mdu    = (bus.ALUOperation == OP_MULTU) || op_div;
    assign accept    = bus.in_valid && bus.in_ready;
    assign last_step = (cnt == SHAMT_W'(WIDTH - 1));
    assign alu_res   = alu_op(bus.ALUOperation, bus.A, bus.B, bus.Shamt, hi, lo);

    // One multiply/divide iteration. In both cases the final {wk_hi, wk_lo}
    // is {HI, LO}. For divide, the borrow out of trial decides the quotient
    // bit; a zero divisor never borrows, which yields LO=all ones, HI=A.
    always_comb begin
        sum     = '0;
        shifted = '0;
        trial   = '0;
        step_hi = wk_hi;
        step_lo = wk_lo;
        if (is_div) begin
            shifted = {wk_hi, wk_lo[WIDTH-1]};
            trial   = shifted - {1'b0, opnd};
            if (trial[WIDTH]) begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {wk_lo[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {wk_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            sum = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
            {step_hi, step_lo} = {sum, wk_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b1;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE, DONE: begin
                bus.out_valid = (state == DONE);
                if (bus.in_valid) begin
                    state_n = is_mdu ? RUN : DONE;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                bus.in_ready = 1'b0;
                bus.busy     = 1'b1;
                if (last_step) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage boundary: accept / iteration edge -> registered result, HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            result_p1 <= '0;
            zero_p1   <= 1'b1;
        end else if (accept) begin
            if (is_mdu) begin
                cnt <= '0;
            end else begin
                result_p1 <= alu_res;
                zero_p1   <= (alu_res == '0);
            end
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (last_step) begin
                hi        <= step_hi;
                lo        <= step_lo;
                result_p1 <= step_lo;
                zero_p1   <= (step_lo == '0);
            end
        end
    end

    // Working set is fully reloaded on every multiply/divide accept
    always_ff @(posedge clk) begin
        if (accept && is_mdu) begin
            is_div <= op_div;
            opnd   <= op_div ? bus.B : bus.A;
            wk_hi  <= '0;
            wk_lo  <= op_div ? bus.A : bus.B;
        end else if (state == RUN) begin
            wk_hi <= step_hi;
            wk_lo <= step_lo;
        end
    end

    assign bus.ALUResult = result_p1;
    assign bus.Zero      = zero_p1;

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
// Drives a WIDTH=32 and a WIDTH=16 instance through a shared stimulus path and
// compares every result against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_alu;
    logic        clk;
    logic        rst_n;
    logic        iv;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    bit          sel16;

    logic        ov, rdy, bsy, zr;
    logic [31:0] res;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] hi_m [2];
    logic [31:0] lo_m [2];

    multicycle_alu_if #(.WIDTH(32)) bus32 ();
    multicycle_alu_if #(.WIDTH(16)) bus16 ();

    multicycle_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32));
    multicycle_alu #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst_n), .bus(bus16));

    assign bus32.in_valid     = iv & ~sel16;
    assign bus32.ALUOperation = op;
    assign bus32.A            = a;
    assign bus32.B            = b;
    assign bus32.Shamt        = sh;
    assign bus16.in_valid     = iv & sel16;
    assign bus16.ALUOperation = op;
    assign bus16.A            = a[15:0];
    assign bus16.B            = b[15:0];
    assign bus16.Shamt        = sh[3:0];

    always_comb begin
        if (sel16) begin
            ov  = bus16.out_valid;
            rdy = bus16.in_ready;
            bsy = bus16.busy;
            zr  = bus16.Zero;
            res = {16'h0000, bus16.ALUResult};
        end else begin
            ov  = bus32.out_valid;
            rdy = bus32.in_ready;
            bsy = bus32.busy;
            zr  = bus32.Zero;
            res = bus32.ALUResult;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: w-bit ALU semantics computed with 64-bit arithmetic
    function automatic void model(input int w, input logic [3:0] o,
                                  input logic [31:0] av, input logic [31:0] bv, input int s,
                                  input logic [31:0] hi_i, input logic [31:0] lo_i,
                                  output logic [31:0] r, output logic [31:0] hi_o,
                                  output logic [31:0] lo_o);
        longint unsigned m, x, y, p, t;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        x  = {32'h0, av} & m;
        y  = {32'h0, bv} & m;
        sa = ((x >> (w - 1)) & 64'd1) != 0 ? longint'(x | ~m) : longint'(x);
        sb = ((y >> (w - 1)) & 64'd1) != 0 ? longint'(y | ~m) : longint'(y);
        hi_o = hi_i;
        lo_o = lo_i;
        t = 0;
        case (o)
            4'd0:  t = x & y;
            4'd1:  t = x | y;
            4'd2:  t = ~(x | y) & m;
            4'd3:  t = (x + y) & m;
            4'd4:  t = (x - y) & m;
            4'd5:  t = (y << (w / 2)) & m;
            4'd6:  t = (y << s) & m;
            4'd7:  t = y >> s;
            4'd8:  t = longint'(sb >>> s) & m;
            4'd9:  t = (sa < sb) ? 64'd1 : 64'd0;
            4'd10: begin
                p    = x * y;
                lo_o = 32'(p & m);
                hi_o = 32'((p >> w) & m);
                t    = {32'h0, lo_o};
            end
            4'd11: begin
                if (y == 0) begin
                    lo_o = 32'(m);
                    hi_o = 32'(x);
                end else begin
                    lo_o = 32'(x / y);
                    hi_o = 32'(x % y);
                end
                t = {32'h0, lo_o};
            end
            4'd12: t = {32'h0, hi_i};
            4'd13: t = {32'h0, lo_i};
            default: t = 0;
        endcase
        r = 32'(t);
    endfunction

    // Issue one request on the selected instance and check the response.
    // With poke set, random requests are thrown at the unit while it is busy.
    task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] s, input bit poke);
        int w, k, lat, rdy_low, se;
        logic [31:0] er, hn, ln;
        bit md;
        w  = sel16 ? 16 : 32;
        k  = sel16 ? 1 : 0;
        se = sel16 ? int'(s[3:0]) : int'(s);
        md = (o == 4'd10) || (o == 4'd11);
        @(negedge clk);
        iv = 1'b1; op = o; a = av; b = bv; sh = s;
        model(w, o, av, bv, se, hi_m[k], lo_m[k], er, hn, ln);
        hi_m[k] = hn;
        lo_m[k] = ln;
        @(negedge clk);
        iv = 1'b0;
        lat = 1;
        rdy_low = 0;
        while (!ov && lat <= w + 4) begin
            if (!rdy) rdy_low++;
            if (poke) begin
                iv = 1'($urandom_range(0, 1));
                op = 4'($urandom_range(0, 15));
                a  = $urandom;
                b  = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        iv = 1'b0;
        check("latency", 32'(lat), md ? 32'(w + 1) : 32'd1);
        check($sformatf("result op%0d", o), res, er);
        check($sformatf("zero op%0d", o), 32'(zr), (er == 32'h0) ? 32'd1 : 32'd0);
        if (md) check("ready_low_cycles", 32'(rdy_low), 32'(w));
    endtask

    logic [31:0] held;

    initial begin
        iv = 1'b0; op = 4'd0; a = '0; b = '0; sh = '0; sel16 = 1'b0;
        hi_m[0] = '0; lo_m[0] = '0; hi_m[1] = '0; lo_m[1] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(ov), 32'd0);
        check("rst_in_ready", 32'(rdy), 32'd1);
        check("rst_busy", 32'(bsy), 32'd0);
        check("rst_result", res, 32'd0);
        check("rst_zero", 32'(zr), 32'd1);
        rst_n = 1'b1;

        // back-to-back ADD then SUB
        @(negedge clk);
        iv = 1'b1; op = 4'd3; a = 32'd5; b = 32'd7;
        @(negedge clk);
        check("b2b_add_valid", 32'(ov), 32'd1);
        check("b2b_add_result", res, 32'd12);
        check("b2b_add_zero", 32'(zr), 32'd0);
        op = 4'd4; a = 32'd3; b = 32'd3;
        @(negedge clk);
        iv = 1'b0;
        check("b2b_sub_valid", 32'(ov), 32'd1);
        check("b2b_sub_result", res, 32'd0);
        check("b2b_sub_zero", 32'(zr), 32'd1);

        run_op(4'd9, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
        run_op(4'd8, 32'd0, 32'h80000000, 5'd4, 1'b0);
        run_op(4'd7, 32'd0, 32'h80000000, 5'd4, 1'b0);
        run_op(4'd10, 32'hFFFFFFFF, 32'd2, 5'd0, 1'b0);
        run_op(4'd12, 32'd0, 32'd0, 5'd0, 1'b0);
        run_op(4'd13, 32'd0, 32'd0, 5'd0, 1'b0);
        run_op(4'd11, 32'd100, 32'd7, 5'd0, 1'b1);
        run_op(4'd12, 32'd0, 32'd0, 5'd0, 1'b0);
        run_op(4'd11, 32'h1234, 32'd0, 5'd0, 1'b1);
        run_op(4'd12, 32'd0, 32'd0, 5'd0, 1'b0);
        run_op(4'd14, 32'h1, 32'h2, 5'd0, 1'b0);

        // result holds once out_valid drops
        held = res;
        repeat (3) @(negedge clk);
        check("hold_valid", 32'(ov), 32'd0);
        check("hold_result", res, held);

        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        // reset ten cycles into a MULTU
        @(negedge clk);
        iv = 1'b1; op = 4'd10; a = 32'hDEADBEEF; b = 32'h12345;
        @(negedge clk);
        iv = 1'b0;
        repeat (9) @(negedge clk);
        check("run_busy", 32'(bsy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(ov), 32'd0);
        check("midrst_busy", 32'(bsy), 32'd0);
        check("midrst_in_ready", 32'(rdy), 32'd1);
        check("midrst_result", res, 32'd0);
        check("midrst_zero", 32'(zr), 32'd1);
        hi_m[0] = '0; lo_m[0] = '0; hi_m[1] = '0; lo_m[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd12, 32'd0, 32'd0, 5'd0, 1'b0);
        run_op(4'd13, 32'd0, 32'd0, 5'd0, 1'b0);

        // WIDTH=16 instance
        sel16 = 1'b1;
        run_op(4'd5, 32'd0, 32'h00AB, 5'd0, 1'b0);
        run_op(4'd10, 32'h00FF, 32'h0101, 5'd0, 1'b0);
        run_op(4'd12, 32'd0, 32'd0, 5'd0, 1'b0);
        run_op(4'd13, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom,
                   5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Executes the existing logic, arithmetic and shift operations with a one-cycle registered latency.
- Adds SRA and SLT, plus an iterative unsigned multiply/divide unit with HI/LO result registers and MFHI/MFLO readback.
- Sits in the execute stage. A valid/ready handshake lets the control unit stall while multiply/divide runs.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and at least 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request this cycle
- ALUOperation  input  4  operation code, sampled on accept
- A  input  WIDTH  operand A, sampled on accept
- B  input  WIDTH  operand B, sampled on accept
- Shamt  input  SHAMT_W  shift amount, sampled on accept
- out_valid  output  1  one-cycle pulse; ALUResult/Zero updated this cycle
- ALUResult  output  WIDTH  registered result
- Zero  output  1  registered, 1 when ALUResult==0
- busy  output  1  multiply/divide iteration in progress

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 NOR, 0011 ADD (wraps mod 2^WIDTH), 0100 SUB (wraps).
  - 0101 LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 0110 SLL B<<Shamt, 0111 SRL B>>Shamt logical, 1000 SRA B>>>Shamt arithmetic.
  - 1001 SLT: 1 if signed A<B, else 0.
  - 1010 MULTU, 1011 DIVU, 1100 MFHI, 1101 MFLO.
  - 1110, 1111 undefined: ALUResult=0, Zero=1.
- Accept: in_valid && in_ready on a rising edge. in_valid while in_ready=0 is ignored, with no queuing.
- States: IDLE, RUN, DONE.
  - in_ready = (state != RUN); busy = (state == RUN).
- Single-cycle ops (all except MULTU/DIVU):
  - Accept edge registers ALUResult and Zero, and state goes to DONE.
  - out_valid=1 in the following cycle, i.e. latency 1.
  - MFHI/MFLO return the HI/LO value as it stood at the accept edge.
- MULTU/DIVU:
  - Accept edge latches the operands, clears the iteration counter and moves to RUN.
  - Exactly WIDTH RUN edges follow, one shift-add or restoring-subtract step each.
  - The WIDTH-th RUN edge writes HI/LO and ALUResult=LO, with Zero from LO, and moves to DONE.
  - out_valid is high in the cycle after that edge, i.e. WIDTH+1 cycles after accept; in_ready is low for exactly WIDTH cycles.
- MULTU result: {HI,LO} = A*B, full 2*WIDTH-bit unsigned product.
- DIVU result: LO = A/B, HI = A%B, unsigned.
  - Divide by zero: LO = all ones, HI = A; not flagged.
- HI/LO are written only on multiply/divide completion.
- DONE lasts one cycle and accepts a new request (back-to-back).
  - With no request, DONE goes to IDLE and out_valid drops.
- ALUResult/Zero hold their values between out_valid pulses.
- Reset (asynchronous, any time, including mid-RUN):
  - state=IDLE; counter, HI, LO, ALUResult=0; Zero=1; out_valid=0; busy=0; in_ready=1.
  - An in-flight multiply/divide is discarded.
- Shamt ≥ WIDTH is impossible by port width.

Test Plan:
- WIDTH=32, ADD A=5 B=7 -> out_valid one cycle after accept, ALUResult=12, Zero=0. Then SUB A=3 B=3 back-to-back -> next cycle ALUResult=0, Zero=1.
- SLT A=0xFFFFFFFF B=1 -> ALUResult=1. SRA B=0x80000000 Shamt=4 -> 0xF8000000. SRL with the same operands -> 0x08000000.
- MULTU A=0xFFFFFFFF B=2 -> in_ready=0 for 32 cycles, out_valid at cycle 33, ALUResult=LO=0xFFFFFFFE. Then MFHI -> 0x00000001, MFLO -> 0xFFFFFFFE.
- DIVU A=100 B=7 -> LO=14, HI=2. DIVU A=0x1234 B=0 -> LO=0xFFFFFFFF, HI=0x1234. in_valid pulses while busy leave the result unchanged.
- Assert reset 10 cycles into a MULTU -> immediately out_valid=0, busy=0, in_ready=1, ALUResult=0, Zero=1. Subsequent MFHI -> 0.
- WIDTH=16: LUI B=0x00AB -> 0xAB00; MULTU 0x00FF*0x0101 -> HI=0x0000, LO=0xFFFF, out_valid at cycle 17.
